// File: rtl/texture_ctrl.sv
// Texture selector: debounced up/down buttons plus MMIO index/status registers.
// Optional auto-advance timer is compiled in with `define TEXTURE_AUTOCYCLE_EN.
module texture_ctrl #(
    parameter int          NUM_TEXTURES    = 8,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [11:0] IDX_ADDR        = 12'hFF0,
    parameter logic [11:0] STAT_ADDR       = 12'hFF1,
    parameter int          AUTO_PERIOD     = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic [11:0] addr,
    input  logic        mwe,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_rdata,
    output logic [31:0] rdata,
    output logic [3:0]  texture_idx,
    output logic        event_pending
);

    localparam int         CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_TEXTURES - 1);

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
    logic [CW-1:0] dcnt_q [2];

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
        end else begin
            sync1_q    <= {BTND, BTNU};
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (dcnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        deb_q[i]  <= sync2_q[i];
                        dcnt_q[i] <= '0;
                    end else begin
                        dcnt_q[i] <= dcnt_q[i] + 1'b1;
                    end
                end else begin
                    dcnt_q[i] <= '0;
                end
            end
        end
    end

    logic [3:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       auto_en_q, auto_en_d;
    logic       pend_q;
    logic       up_acc, dn_acc, acc, idx_wr, stat_wr, auto_tick;

`ifdef TEXTURE_AUTOCYCLE_EN
    localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    logic [TW-1:0] timer_q, timer_d;
    wire           unused_wdata = ^{wdata[31:9], wdata[7:4]};
`else
    wire           unused_wdata = ^{wdata[31:8], wdata[7:4]};
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        up_acc    = press_q[0] & ~press_q[1];
        dn_acc    = press_q[1] & ~press_q[0];
        acc       = up_acc | dn_acc;
        idx_wr    = mwe && (addr == IDX_ADDR) && ({1'b0, wdata[3:0]} < 5'(NUM_TEXTURES));
        stat_wr   = mwe && (addr == STAT_ADDR);
        auto_tick = 1'b0;
        auto_en_d = 1'b0;
`ifdef TEXTURE_AUTOCYCLE_EN
        auto_tick = auto_en_q && (timer_q == TW'(AUTO_PERIOD - 1));
        auto_en_d = stat_wr ? wdata[8] : auto_en_q;
        // Timer idles at 0 while disabled, which also covers the 0->1 restart.
        timer_d   = (auto_en_q && !(acc || idx_wr || auto_tick)) ? timer_q + 1'b1 : '0;
`endif

        idx_d = idx_q;
        if (idx_wr)
            idx_d = wdata[3:0];
        else if (dn_acc)
            idx_d = (idx_q == 4'd0) ? LAST_IDX : idx_q - 4'd1;
        else if (up_acc || auto_tick)
            idx_d = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;

        dir_d = acc ? up_acc : dir_q;

        cnt_d = cnt_q;
        if (stat_wr)
            cnt_d = {7'd0, acc};
        else if (acc && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            auto_en_q <= 1'b0;
            pend_q    <= 1'b0;
`ifdef TEXTURE_AUTOCYCLE_EN
            timer_q   <= '0;
`endif
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            auto_en_q <= auto_en_d;
            pend_q    <= (cnt_d != 8'd0);
`ifdef TEXTURE_AUTOCYCLE_EN
            timer_q   <= timer_d;
`endif
        end
    end

    always_comb begin
        if (addr == IDX_ADDR)
            rdata = {28'd0, idx_q};
        else if (addr == STAT_ADDR)
            rdata = {22'd0, dir_q, auto_en_q, cnt_q};
        else
            rdata = ram_rdata;
    end

    assign texture_idx   = idx_q;
    assign event_pending = pend_q;

endmodule
